// File: rtl/mul_div_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_pkg
// Shared definitions for the MIPS multiply/divide engine:
//   - op encodings MD_MULT..MD_MTLO (value of op_i)
//   - FSM state encoding
//   - default number of divide/multiply iterations
//   - divide-by-zero quotient constants
// -----------------------------------------------------------------------------
package mul_div_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MFHI  = 3'd4;
  localparam logic [2:0] MD_MFLO  = 3'd5;
  localparam logic [2:0] MD_MTHI  = 3'd6;
  localparam logic [2:0] MD_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam int DIV_ITER_DEF = 32;

  // Quotient returned for a zero divisor. The remainder is always rs.
  localparam logic [31:0] DIV0_LO_POS = 32'hFFFF_FFFF;  // DIVU, or DIV with rs >= 0
  localparam logic [31:0] DIV0_LO_NEG = 32'h0000_0001;  // DIV with rs < 0

endpackage

// File: rtl/mul_div_datapath.sv
// -----------------------------------------------------------------------------
// mul_div_datapath
// 64-bit shared accumulator for restoring division and shift-add
// multiplication, plus the final sign-fix / divide-by-zero result logic.
// When MUL_DIV_FAST_MUL_EN is defined, MULT/MULTU instead keep the raw
// operands and form the product with a single sign-extended multiply.
//
// Ports:
//   clk_i, resetn_i     clock, async active-low reset
//   load_i              capture operands (issue cycle)
//   step_i              perform one iteration
//   op_i                op being issued (sampled with load_i)
//   rs_i, rt_i          operands (sampled with load_i)
//   hi_res_o, lo_res_o  final HI/LO value, valid once the iterations are done
// -----------------------------------------------------------------------------
module mul_div_datapath
  import mul_div_pkg::*;
(
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_res_o,
  output logic [31:0] lo_res_o
);

  // acc: divide -> {remainder, dividend/quotient}; multiply -> {partial, multiplier}
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;      // divisor or multiplicand magnitude
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;        // negate quotient / product at the end
  logic        rem_neg_q, rem_neg_d;  // remainder takes the sign of rs
`ifdef MUL_DIV_FAST_MUL_EN
  logic        signed_q, signed_d;
`endif

  logic        signed_op, rs_neg, rt_neg;
  logic [32:0] rem33, sum33;
  logic        ge;
  logic [63:0] prod;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    rs_neg    = signed_op & rs_i[31];
    rt_neg    = signed_op & rt_i[31];

    // Shifted partial remainder needs 33 bits: it can exceed 2^32-1 before the subtract.
    rem33 = acc_q[63:31];
    ge    = rem33 >= {1'b0, opnd_q};
    sum33 = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'h0)};

    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
`ifdef MUL_DIV_FAST_MUL_EN
    signed_d  = signed_q;
`endif

    if (load_i) begin
      is_div_d  = op_i[1];
      neg_d     = rs_neg ^ rt_neg;
      rem_neg_d = rs_neg;
      acc_d     = {32'h0, (rs_neg ? 32'h0 - rs_i : rs_i)};
      opnd_d    = rt_neg ? 32'h0 - rt_i : rt_i;
`ifdef MUL_DIV_FAST_MUL_EN
      signed_d  = signed_op;
      if (!op_i[1]) begin
        acc_d  = {32'h0, rs_i};
        opnd_d = rt_i;
      end
`endif
    end else if (step_i) begin
      if (is_div_q) begin
        // When ge, the difference is below the divisor, so 32 bits hold it.
        acc_d = {(ge ? rem33[31:0] - opnd_q : rem33[31:0]), acc_q[30:0], ge};
      end else begin
        acc_d = {sum33, acc_q[31:1]};
      end
    end
  end

  // NOTE: state flops use non-blocking assignments only.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
`ifdef MUL_DIV_FAST_MUL_EN
      signed_q  <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
`ifdef MUL_DIV_FAST_MUL_EN
      signed_q  <= signed_d;
`endif
    end
  end

  // Sign fix. For a zero divisor the remainder path already yields rs.
  always_comb begin
    prod     = neg_q ? 64'h0 - acc_q : acc_q;
`ifdef MUL_DIV_FAST_MUL_EN
    // 33x33 signed multiply: operands extended by their signedness; low 64 bits kept.
    prod     = {{32{signed_q & acc_q[31]}}, acc_q[31:0]} *
               {{32{signed_q & opnd_q[31]}}, opnd_q};
`endif
    hi_res_o = prod[63:32];
    lo_res_o = prod[31:0];
    if (is_div_q) begin
      hi_res_o = rem_neg_q ? 32'h0 - acc_q[63:32] : acc_q[63:32];
      lo_res_o = neg_q ? 32'h0 - acc_q[31:0] : acc_q[31:0];
      if (opnd_q == 32'h0) begin
        lo_res_o = rem_neg_q ? DIV0_LO_NEG : DIV0_LO_POS;
      end
    end
  end

endmodule

// File: rtl/mul_div_engine.sv
// -----------------------------------------------------------------------------
// mul_div_engine
// Multi-cycle MIPS multiply/divide unit in EX. Runs MULT/MULTU/DIV/DIVU into
// private HI/LO, serves MFHI/MFLO/MTHI/MTLO and requests an EX stall while an
// operation is in flight (IDLE -> BUSY -> DONE).
// Build option: MUL_DIV_FAST_MUL_EN - single-cycle BUSY for MULT/MULTU.
//
// Ports:
//   clk_i, resetn_i   clock, async active-low reset
//   en_i              0 freezes the unit (no issue, no HI/LO write)
//   hold_i            IF/MEM stall; keeps DONE until released
//   flush_i           kills the EX instruction
//   valid_i, op_i     mul/div-class instruction in EX and its op
//   rs_i, rt_i        operands
//   ex_stall_o        EX stall request
//   result_o          MFHI/MFLO read data
//   hi_o, lo_o        architectural HI/LO
// -----------------------------------------------------------------------------
module mul_div_engine
  import mul_div_pkg::*;
#(
  parameter int DIV_ITER = DIV_ITER_DEF
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic        en_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic        valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        ex_stall_o,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CNT_W = $clog2(DIV_ITER + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             start, mt_wr, step;
  logic [CNT_W-1:0] cnt_load;
  logic [31:0]      hi_res, lo_res;

  assign start = (state_q == ST_IDLE) && valid_i && en_i && !op_i[2] && !flush_i;
  assign mt_wr = (state_q == ST_IDLE) && valid_i && en_i && !flush_i &&
                 ((op_i == MD_MTHI) || (op_i == MD_MTLO));

  // Counter value at issue: iterations remaining before the sign-fix cycle.
`ifdef MUL_DIV_FAST_MUL_EN
  assign cnt_load = op_i[1] ? CNT_W'(DIV_ITER) : '0;
`else
  assign cnt_load = CNT_W'(DIV_ITER);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BUSY;
          cnt_d   = cnt_load;
        end else if (mt_wr) begin
          if (op_i == MD_MTHI) hi_d = rs_i;
          else                 lo_d = rs_i;
        end
      end
      ST_BUSY: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (en_i) begin
          if (cnt_q != '0) begin
            step  = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            hi_d    = hi_res;
            lo_d    = lo_res;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // valid_i is not looked at, so the finished instruction is never reissued.
        if (flush_i || (en_i && !hold_i)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mul_div_datapath u_datapath (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .load_i   (start),
    .step_i   (step),
    .op_i     (op_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .hi_res_o (hi_res),
    .lo_res_o (lo_res)
  );

  // Stall rises combinationally in the issue cycle and drops in a flush cycle.
  assign ex_stall_o = start || ((state_q == ST_BUSY) && !flush_i);
  assign result_o   = (op_i == MD_MFHI) ? hi_q : lo_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_engine.sv
module tb_mul_div_engine;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  localparam int DIV_STALL = 34;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int MUL_STALL = 2;
`else
  localparam int MUL_STALL = 34;
`endif

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        en_i, hold_i, flush_i, valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        ex_stall_o;
  logic [31:0] result_o, hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  mul_div_engine dut (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .en_i       (en_i),
    .hold_i     (hold_i),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .op_i       (op_i),
    .rs_i       (rs_i),
    .rt_i       (rt_i),
    .ex_stall_o (ex_stall_o),
    .result_o   (result_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one mul/div op and follow it to DONE. freeze_len > 0 drops en_i for
  // that many cycles starting in the 11th stall cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_stall, input int freeze_len);
    int  stall_cnt;
    bit  stall_in_done;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt; en_i = 1'b1; hold_i = 1'b1;
    #1;
    stall_cnt = 0;
    while (ex_stall_o && stall_cnt < 200) begin
      stall_cnt++;
      @(negedge clk_i);
      if (freeze_len > 0 && stall_cnt == 10) en_i = 1'b0;
      if (freeze_len > 0 && stall_cnt == 10 + freeze_len) en_i = 1'b1;
      #1;
    end
    check({name, " stall"}, stall_cnt, exp_stall);
    check({name, " hi"}, hi_o, exp_hi);
    check({name, " lo"}, lo_o, exp_lo);
    // DONE with hold_i=1 and valid_i still present: no reissue, no stall.
    stall_in_done = 1'b0;
    repeat (3) begin
      @(negedge clk_i); #1;
      if (ex_stall_o) stall_in_done = 1'b1;
    end
    check({name, " done no reissue"}, {31'h0, stall_in_done}, 32'h0);
    op_i = OP_MFHI; #1;
    check({name, " mfhi"}, result_o, exp_hi);
    op_i = OP_MFLO; #1;
    check({name, " mflo"}, result_o, exp_lo);
    valid_i = 1'b0; hold_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    vecs[0]  = '{"divu 100/7",      OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_STALL};
    vecs[1]  = '{"div -100/7",      OP_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, DIV_STALL};
    vecs[2]  = '{"div 5/0",         OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DIV_STALL};
    vecs[3]  = '{"div min/-1",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, DIV_STALL};
    vecs[4]  = '{"mult -1*2",       OP_MULT,  32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, MUL_STALL};
    vecs[5]  = '{"multu ffff*2",    OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE, MUL_STALL};
    vecs[6]  = '{"div -7/0",        OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h1,        DIV_STALL};
    vecs[7]  = '{"divu max/0",      OP_DIVU,  32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, DIV_STALL};
    vecs[8]  = '{"div 100/-7",      OP_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, DIV_STALL};
    vecs[9]  = '{"mult min*min",    OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        MUL_STALL};
    vecs[10] = '{"multu max*max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        MUL_STALL};
    vecs[11] = '{"mult -3*5",       OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MUL_STALL};
    vecs[12] = '{"divu 12345678/1000", OP_DIVU, 32'h12345678, 32'h1000,   32'h678,      32'h12345,    DIV_STALL};
    vecs[13] = '{"div -100/-7",     OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       DIV_STALL};

    resetn_i = 1'b0; en_i = 1'b1; hold_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    op_i = OP_MFLO; rs_i = '0; rt_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset stall", {31'h0, ex_stall_o}, 32'h0);
    check("reset hi", hi_o, 32'h0);
    check("reset lo", lo_o, 32'h0);
    check("reset result", result_o, 32'h0);
    @(negedge clk_i);
    resetn_i = 1'b1;

    // MTHI / MTLO: no stall, readable in the next cycle.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = OP_MTHI; rs_i = 32'hDEADBEEF; #1;
    check("mthi stall", {31'h0, ex_stall_o}, 32'h0);
    @(negedge clk_i);
    op_i = OP_MTLO; rs_i = 32'h0BADF00D; #1;
    check("mtlo stall", {31'h0, ex_stall_o}, 32'h0);
    op_i = OP_MFHI; #1;
    check("mfhi after mthi", result_o, 32'hDEADBEEF);
    op_i = OP_MTLO; #1;
    @(negedge clk_i);
    op_i = OP_MFLO; #1;
    check("mflo after mtlo", result_o, 32'h0BADF00D);
    valid_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
             vecs[i].hi, vecs[i].lo, vecs[i].stall, 0);
    end

    // en_i low for 5 cycles mid-BUSY: stall extends by 5, result unchanged.
    run_op("divu freeze", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_STALL + 5, 5);

    // Flush in BUSY cycle 10: IDLE next edge, HI/LO untouched.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = OP_DIVU; rs_i = 32'd85; rt_i = 32'd3; en_i = 1'b1;
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1; #1;
    check("flush stall drop", {31'h0, ex_stall_o}, 32'h0);
    @(negedge clk_i);
    flush_i = 1'b0; valid_i = 1'b0; #1;
    check("flush stall after", {31'h0, ex_stall_o}, 32'h0);
    check("flush hi kept", hi_o, 32'h2);
    check("flush lo kept", lo_o, 32'd14);
    valid_i = 1'b1; op_i = OP_MTLO; rs_i = 32'h00001234;
    @(negedge clk_i);
    valid_i = 1'b0; #1;
    check("flush back to idle", lo_o, 32'h00001234);

    // Flush together with a start: nothing issues.
    valid_i = 1'b1; op_i = OP_DIV; rs_i = 32'd9; rt_i = 32'd2; flush_i = 1'b1; #1;
    check("flush+start stall", {31'h0, ex_stall_o}, 32'h0);
    @(negedge clk_i);
    valid_i = 1'b0; flush_i = 1'b0; #1;
    check("flush+start no busy", {31'h0, ex_stall_o}, 32'h0);

    // Reset pulse mid-DIV: immediate return to reset values.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = OP_DIV; rs_i = 32'd1000; rt_i = 32'd3;
    repeat (8) @(negedge clk_i);
    resetn_i = 1'b0; valid_i = 1'b0; #1;
    check("rst mid stall", {31'h0, ex_stall_o}, 32'h0);
    check("rst mid hi", hi_o, 32'h0);
    check("rst mid lo", lo_o, 32'h0);
    @(negedge clk_i);
    resetn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    check("rst after stall", {31'h0, ex_stall_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_engine.md
# mul_div_engine

Multi-cycle MIPS multiply/divide engine in the EX stage. Executes MULT/MULTU/DIV/DIVU into private HI/LO registers, serves MFHI/MFLO/MTHI/MTLO, and asserts `ex_stall_o` while an operation is in flight. It is the producer end of the mul/div stall protocol. The pipeline's mul/div result-hold controller drives `en_i` and latches `result_o` while EX is released but IF/MEM still stall.

## Interface
- `DIV_ITER`, default 32: quotient bits, one per BUSY cycle.
- `clk_i`  in  1  clock; all state on rising edge.
- `resetn_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  enable from the result-hold controller. 0 = freeze: no issue, no HI/LO write, state held.
- `hold_i`  in  1  IF or MEM stall active (EX instruction cannot leave).
- `flush_i`  in  1  exception/ERET flush of the EX instruction.
- `valid_i`  in  1  EX holds a mul/div-class instruction.
- `op_i`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- `rs_i`, `rt_i`  in  32  operands.
- `ex_stall_o`  out  1  EX stall request.
- `result_o`  out  32  MFHI/MFLO read data.
- `hi_o`, `lo_o`  out  32  architectural HI/LO.

## Operation
- Reset values: state IDLE, HI=LO=0, counter 0, `ex_stall_o`=0, `result_o`=0.
- States: IDLE, BUSY, DONE.
- Start condition: IDLE & `valid_i` & `en_i` & op∈{0..3} & !`flush_i`.
  - On start, `ex_stall_o`=1 combinationally in that same cycle.
  - Operands are captured, sign-stripped to magnitudes for signed ops, and the counter is loaded.
  - Next state is BUSY.
- BUSY:
  - `ex_stall_o`=1 throughout.
  - Divide: one restoring iteration per cycle, then one sign-fix cycle.
  - HI/LO are written at the edge ending the last BUSY cycle; next state is DONE.
- DONE:
  - `ex_stall_o`=0; `valid_i` is ignored, so the completed instruction is never reissued.
  - Exit to IDLE on the first edge with `en_i`=1 & `hold_i`=0.
- MTHI/MTLO: in IDLE with `en_i`=1 & !`flush_i`, write `rs_i` at the edge. No stall.
- `result_o` is combinational: HI when op=4, LO otherwise.
- Arithmetic:
  - Products: MULT signed 64-bit, MULTU unsigned 64-bit; HI=[63:32], LO=[31:0].
  - Divide: LO=quotient, HI=remainder. Signed quotient truncates toward zero; remainder takes the sign of `rs_i`.
  - Divide by zero is defined (not trapped): DIVU gives LO=0xFFFFFFFF, HI=rs. DIV gives LO = rs<0 ? 1 : 0xFFFFFFFF, HI=rs.
  - 0x80000000 DIV 0xFFFFFFFF: LO=0x80000000, HI=0.
- Boundaries:
  - `flush_i` in BUSY/DONE: return to IDLE next edge, HI/LO untouched. `ex_stall_o` drops in the flush cycle.
  - `en_i`=0 in BUSY: counter and partials freeze, `ex_stall_o` stays 1.
  - `resetn_i` low mid-operation: immediate return to reset values; partial result discarded.
  - Simultaneous `flush_i` and start: no start.

## Timing
- DIV/DIVU: `ex_stall_o` high for 1 + `DIV_ITER` + 1 = 34 cycles (issue + 32 iterations + sign fix). HI/LO are visible in the first DONE cycle.
- MULT/MULTU iterative: same 34-cycle stall (32 shift-add iterations + sign fix).
- MTHI/MTLO: 0 stall cycles; the value is readable via MFHI/MFLO in the next cycle.
- No internal HI/LO forwarding is required, because mul/div ops serialize through the stall.

## Configuration
- `MUL_DIV_FAST_MUL_EN` defined:
  - MULT/MULTU use one registered 33x33 signed multiply.
  - BUSY lasts 1 cycle, so `ex_stall_o` is high for 2 cycles total.
- `MUL_DIV_FAST_MUL_EN` undefined:
  - Iterative shift-add multiplier sharing the divider's 64-bit accumulator.
  - Stall is 34 cycles.
- Divide is always iterative.

## Structure
- The shared `mul_div_pkg` holds:
  - the op encodings (`MD_MULT`..`MD_MTLO`);
  - the state encoding;
  - the `DIV_ITER` default;
  - the divide-by-zero result constants.
- One sub-module, `mul_div_datapath`, holds the accumulator, iteration step and sign fix.
- `mul_div_engine` keeps the FSM, counter, HI/LO and handshake.

## Test plan
- DIVU rs=100, rt=7: stall 34 cycles → LO=14, HI=2. DONE ignores the still-present `valid_i`.
- DIV rs=0xFFFFFF9C (-100), rt=7 → LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- DIV rs=5, rt=0 → LO=0xFFFFFFFF, HI=5. Also 0x80000000/-1 → LO=0x80000000, HI=0.
- MULT rs=0xFFFFFFFF, rt=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE. Run with and without `MUL_DIV_FAST_MUL_EN`; check stall lengths 2 and 34.
- DIVU in flight with `en_i`=0 for 5 cycles mid-BUSY → stall extends by 5, same result. In DONE with `hold_i`=1, the state is held and no reissue occurs.
- `flush_i` at BUSY cycle 10 → IDLE next edge, HI/LO unchanged. `resetn_i` pulse mid-DIV → HI=LO=0, `ex_stall_o`=0 immediately.
